// File: rtl/psum_drain_pkg.sv
// Shared sizing, state encoding and buffer addressing for the partial-sum readout engine.
package psum_drain_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int ACC_W     = 24;
  localparam int OUT_W     = 8;
  localparam int SHIFT_W   = 5;
  localparam int SHIFT_MAX = 23;
  localparam int SAT_CNT_W = 16;

  localparam int ROW_W     = COLS * ACC_W;
  localparam int ARRAY_W   = ROWS * ROW_W;
  localparam int OUT_ROW_W = COLS * OUT_W;
  localparam int ROW_IDX_W = $clog2(ROWS);
  localparam int POP_W     = $clog2(COLS + 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int elem_offset(input int r, input int c);
    return r * ROW_W + c * ACC_W;
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Snapshot-capture and row-stream handshakes of the readout engine, bundled as one interface.
interface psum_drain_if;
  import psum_drain_pkg::*;

  logic                   snap_valid;
  logic                   snap_ready;
  logic [ARRAY_W-1:0]     acc_array;
  logic [SHIFT_W-1:0]     shift;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_ROW_W-1:0]   out_data;
  logic [ROW_IDX_W-1:0]   out_row;
  logic                   out_last;
  logic                   out_sat;
  logic [SAT_CNT_W-1:0]   sat_count;

  modport master (
    output snap_valid, acc_array, shift, out_ready,
    input  snap_ready, out_valid, out_data, out_row, out_last, out_sat, sat_count
  );

  modport slave (
    input  snap_valid, acc_array, shift, out_ready,
    output snap_ready, out_valid, out_data, out_row, out_last, out_sat, sat_count
  );

endinterface

// File: rtl/psum_drain_requant_sat.sv
// One-element requantizer: rounding arithmetic right shift (half toward +inf) then
// saturation of the 25-bit intermediate to signed OUT_W.
module requant_sat
  import psum_drain_pkg::*;
(
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   q,
  output logic               sat_flag
);

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-(1 <<< (OUT_W-1)));

  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] v;
  logic                  over;
  logic                  under;

  // The extra intermediate bit keeps acc + half from wrapping at the positive rail.
  always_comb begin
    half = '0;
    if (shift != '0) begin
      half[shift - 1'b1] = 1'b1;
    end
    v     = ($signed({acc[ACC_W-1], acc}) + half) >>> shift;
    over  = v > Q_MAX;
    under = v < Q_MIN;
    sat_flag = over || under;
    if (over) begin
      q = Q_MAX[OUT_W-1:0];
    end else if (under) begin
      q = Q_MIN[OUT_W-1:0];
    end else begin
      q = v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Accumulator readout engine: captures a full partial-sum snapshot, then streams one
// requantized row per cycle while accumulating a sticky saturation count.
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  psum_drain_if.slave bus
);

  state_t                 state;
  logic [ROW_IDX_W-1:0]   row_ptr;
  logic [ARRAY_W-1:0]     buffer;
  logic [SHIFT_W-1:0]     shift_q;
  logic [SHIFT_W-1:0]     eff_shift;
  logic [SAT_CNT_W-1:0]   sat_count;
  logic [SAT_CNT_W:0]     sat_sum;
  logic [POP_W-1:0]       row_sat_cnt;
  logic [COLS-1:0]        sat_flags;
  logic [OUT_ROW_W-1:0]   row_data;
  logic                   stream;
  logic                   last_row;
  logic                   snap_fire;
  logic                   row_fire;

  assign stream    = state == STREAM;
  assign last_row  = row_ptr == ROW_IDX_W'(ROWS - 1);
  assign eff_shift = (bus.shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : bus.shift;
  assign row_fire  = stream && bus.out_ready;
  assign snap_fire = bus.snap_valid && bus.snap_ready;

  // A new snapshot may land on the final-row handshake so tiles stream without a bubble.
  assign bus.snap_ready = !rst && (!stream || (last_row && bus.out_ready));

  for (genvar c = 0; c < COLS; c++) begin : g_col
    requant_sat u_requant (
      .acc      (buffer[elem_offset(int'(row_ptr), c) +: ACC_W]),
      .shift    (shift_q),
      .q        (row_data[c*OUT_W +: OUT_W]),
      .sat_flag (sat_flags[c])
    );
  end

  always_comb begin
    row_sat_cnt = '0;
    for (int c = 0; c < COLS; c++) begin
      row_sat_cnt = row_sat_cnt + POP_W'(sat_flags[c]);
    end
    sat_sum = {1'b0, sat_count} + (SAT_CNT_W+1)'(row_sat_cnt);
  end

  assign bus.out_valid = stream;
  assign bus.out_row   = row_ptr;
  assign bus.out_last  = stream && last_row;
  assign bus.out_data  = row_data;
  assign bus.out_sat   = stream && (|sat_flags);
  assign bus.sat_count = sat_count;

  // Capture takes priority over row advance; the two coincide only on the final row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_ptr   <= '0;
      buffer    <= '0;
      shift_q   <= '0;
      sat_count <= '0;
    end else begin
      if (row_fire) begin
        sat_count <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
      end
      if (snap_fire) begin
        buffer  <= bus.acc_array;
        shift_q <= eff_shift;
        row_ptr <= '0;
        state   <= STREAM;
      end else if (row_fire) begin
        if (last_row) begin
          state <= IDLE;
        end else begin
          row_ptr <= row_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed and randomized bench for psum_drain, checked against an integer-arithmetic
// model of the requantization rules and the sticky saturation total.
module tb_psum_drain;
  import psum_drain_pkg::*;

  localparam int CW = 128;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  psum_drain_if bus ();

  psum_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cur_m [ROWS][COLS];
  int nxt_m [ROWS][COLS];
  int cur_shift;
  int exp_sat;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((a + 2^(s-1)) / 2^s) with plain integer division, then clamp.
  function automatic void refElem(input int a, input int s, output int q, output bit sat);
    int es;
    int d;
    int n;
    int v;
    es = (s > SHIFT_MAX) ? SHIFT_MAX : s;
    if (es == 0) begin
      v = a;
    end else begin
      d = 1 << es;
      n = a + d / 2;
      v = (n >= 0) ? n / d : -((-n + d - 1) / d);
    end
    sat = (v > 127) || (v < -128);
    q   = (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  task automatic fillTile(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (mode)
          0: nxt_m[r][c] = r * 16 + c;
          1: nxt_m[r][c] = 1000;
          2: nxt_m[r][c] = int'($urandom_range(0, 600)) - 300;
          3: nxt_m[r][c] = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
          default: nxt_m[r][c] = 0;
        endcase
      end
    end
  endtask

  task automatic packNext();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.acc_array[(r*COLS + c)*ACC_W +: ACC_W] = ACC_W'(nxt_m[r][c]);
      end
    end
  endtask

  task automatic junkInputs();
    for (int i = 0; i < ARRAY_W / 32; i++) begin
      bus.acc_array[i*32 +: 32] = $urandom;
    end
    bus.shift = SHIFT_W'($urandom_range(0, 31));
  endtask

  task automatic checkOutput(input int r, output int nsat);
    logic [CW-1:0] ed;
    int  q;
    bit  sat;
    ed   = '0;
    nsat = 0;
    for (int c = 0; c < COLS; c++) begin
      refElem(cur_m[r][c], cur_shift, q, sat);
      ed[c*OUT_W +: OUT_W] = OUT_W'(q);
      nsat += int'(sat);
    end
    check("out_valid", CW'(bus.out_valid), CW'(1));
    check("out_row",   CW'(bus.out_row),   CW'(r));
    check("out_last",  CW'(bus.out_last),  CW'(r == ROWS - 1));
    check("out_data",  CW'(bus.out_data),  ed);
    check("out_sat",   CW'(bus.out_sat),   CW'(nsat != 0));
    check("sat_count", CW'(bus.sat_count), CW'(exp_sat));
  endtask

  task automatic acceptRow(input int nsat);
    exp_sat = (exp_sat + nsat > 65535) ? 65535 : exp_sat + nsat;
  endtask

  // Entered and left on a falling edge; stalls hold out_ready low before the handshake.
  task automatic streamRow(input int r, input int stall);
    int nsat;
    for (int k = 0; k < stall; k++) begin
      bus.out_ready = 1'b0;
      #1;
      checkOutput(r, nsat);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput(r, nsat);
    @(posedge clk);
    acceptRow(nsat);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int s);
    packNext();
    bus.shift      = SHIFT_W'(s);
    bus.snap_valid = 1'b1;
    #1;
    check("snap_ready_idle", CW'(bus.snap_ready), CW'(1));
    @(posedge clk);
    cur_m     = nxt_m;
    cur_shift = s;
    @(negedge clk);
    bus.snap_valid = 1'b0;
    junkInputs();
  endtask

  task automatic streamTile(input int stall_row, input int stall_len, input bit rnd_stalls);
    for (int r = 0; r < ROWS; r++) begin
      if (rnd_stalls) streamRow(r, int'($urandom_range(0, 2)));
      else            streamRow(r, (r == stall_row) ? stall_len : 0);
    end
    #1;
    check("idle_out_valid",  CW'(bus.out_valid),  CW'(0));
    check("idle_snap_ready", CW'(bus.snap_ready), CW'(1));
    check("idle_sat_count",  CW'(bus.sat_count), CW'(exp_sat));
  endtask

  initial begin
    int nsat;
    rst            = 1'b1;
    bus.snap_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.acc_array  = '0;
    bus.shift      = '0;
    exp_sat        = 0;
    cur_shift      = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_snap_ready", CW'(bus.snap_ready), CW'(0));
    check("rst_out_valid",  CW'(bus.out_valid),  CW'(0));
    check("rst_sat_count",  CW'(bus.sat_count),  CW'(0));
    check("rst_out_data",   CW'(bus.out_data),   CW'(0));
    check("rst_out_row",    CW'(bus.out_row),    CW'(0));
    check("rst_out_last",   CW'(bus.out_last),   CW'(0));
    check("rst_out_sat",    CW'(bus.out_sat),    CW'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] ramp tile, shift 0");
    fillTile(0);
    applyStimulus(0);
    streamTile(-1, 0, 1'b0);
    check("ramp_sat_total", CW'(bus.sat_count), CW'(128));

    $display("[TB] rounding at shift 1");
    fillTile(9);
    nxt_m[0][0] = 5;
    nxt_m[0][1] = -5;
    nxt_m[0][2] = 32'h007F_FFFF;
    applyStimulus(1);
    streamTile(-1, 0, 1'b0);
    fillTile(9);
    nxt_m[0][0] = -1000;
    applyStimulus(2);
    streamTile(-1, 0, 1'b0);
    check("round_sat_total", CW'(bus.sat_count), CW'(130));

    $display("[TB] shift clamp at 31");
    fillTile(2);
    nxt_m[0][0] = 32'h007F_FFFF;
    nxt_m[0][1] = 32'h003F_FFFF;
    nxt_m[0][2] = -8388608;
    applyStimulus(31);
    streamTile(-1, 0, 1'b0);

    $display("[TB] backpressure at row 3");
    fillTile(3);
    applyStimulus(int'($urandom_range(0, 12)));
    streamTile(3, 5, 1'b0);

    $display("[TB] back-to-back tiles");
    fillTile(2);
    applyStimulus(1);
    for (int r = 0; r < ROWS - 1; r++) begin
      if (r == 5) begin
        bus.snap_valid = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        check("b2b_mid_snap_ready", CW'(bus.snap_ready), CW'(0));
        streamRow(r, 0);
        bus.snap_valid = 1'b0;
      end else begin
        streamRow(r, 0);
      end
    end
    fillTile(3);
    packNext();
    bus.shift      = SHIFT_W'(20);
    bus.snap_valid = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    checkOutput(ROWS - 1, nsat);
    check("b2b_last_snap_ready", CW'(bus.snap_ready), CW'(1));
    @(posedge clk);
    acceptRow(nsat);
    cur_m     = nxt_m;
    cur_shift = 20;
    @(negedge clk);
    bus.snap_valid = 1'b0;
    junkInputs();
    streamTile(-1, 0, 1'b0);

    $display("[TB] randomized tiles");
    for (int t = 0; t < 6; t++) begin
      fillTile(int'($urandom_range(2, 3)));
      applyStimulus(int'($urandom_range(0, 31)));
      streamTile(-1, 0, 1'b1);
    end

    $display("[TB] reset mid-stream at row 9");
    fillTile(3);
    applyStimulus(4);
    for (int r = 0; r < 9; r++) streamRow(r, 0);
    rst = 1'b1;
    #1;
    check("midrst_snap_ready", CW'(bus.snap_ready), CW'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out_valid", CW'(bus.out_valid),  CW'(0));
    check("midrst_sat_count", CW'(bus.sat_count),  CW'(0));
    check("midrst_out_data",  CW'(bus.out_data),   CW'(0));
    check("midrst_rst_ready", CW'(bus.snap_ready), CW'(0));
    rst     = 1'b0;
    exp_sat = 0;
    @(negedge clk);
    #1;
    check("postrst_snap_ready", CW'(bus.snap_ready), CW'(1));
    check("postrst_out_valid",  CW'(bus.out_valid),  CW'(0));
    @(negedge clk);

    $display("[TB] sticky saturation counter");
    for (int t = 0; t < 260; t++) begin
      fillTile(1);
      applyStimulus(0);
      streamTile(-1, 0, 1'b0);
    end
    check("sat_sticky", CW'(bus.sat_count), CW'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Accumulator readout engine for the 16×16 MAC array. It captures a full 6144-bit snapshot of the 24-bit partial-sum array in one handshake. It then streams the snapshot out one row per cycle, requantizing each element to signed 8-bit with a programmable rounding right-shift and saturation. The block sits downstream of the MAC array latch outputs and upstream of the result writeback / output buffer.

## Interface
- ROWS, 16, number of accumulator rows (MAC units)
- COLS, 16, accumulators per row
- ACC_W, 24, accumulator width (signed)
- OUT_W, 8, requantized output width (signed)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- snap_valid  in  1  acc_array/shift valid for capture
- snap_ready  out  1  block can accept a snapshot
- acc_array  in  ROWS*COLS*ACC_W (6144)  element (r,c) at bits [r*384 + c*24 +: 24], two's complement
- shift  in  5  right-shift amount, sampled with snapshot
- out_valid  out  1  out_data holds a row
- out_ready  in  1  consumer accepts row
- out_data  out  COLS*OUT_W (128)  element c at bits [c*8 +: 8]
- out_row  out  4  row index of out_data
- out_last  out  1  out_row == ROWS-1
- out_sat  out  1  at least one element of the current row saturated
- sat_count  out  16  cumulative saturated-element count, sticky at 0xFFFF

## Operation
- States: IDLE, STREAM.
- IDLE: snap_ready=1. On snap_valid&&snap_ready, register acc_array into the buffer, register the effective shift, set row_ptr=0, and go to STREAM.
- Effective shift = min(shift, 23).
- STREAM: out_valid=1, out_row=row_ptr. out_data/out_sat are a combinational function of buffer row row_ptr and the registered shift only, with no path from input ports.
- On out_valid&&out_ready: add the row's saturated-element count to sat_count (clamp at 0xFFFF). If row_ptr<15, increment row_ptr. Otherwise leave STREAM.
- Back-to-back capture: in STREAM, snap_ready = (row_ptr==15) && out_ready. A snapshot accepted on the last-row handshake reloads the buffer, sets row_ptr=0, and stays in STREAM. Otherwise the block goes to IDLE.
- Requant per element, 25-bit signed intermediate:
  - s==0: v = acc.
  - s>0: v = (acc + (1<<(s-1))) >>> s, i.e. round half toward +inf.
  - v>127 → 127, v<−128 → −128; either case counts as saturated.
- Reset: state IDLE, row_ptr 0, buffer 0, shift reg 0, sat_count 0, out_valid 0, out_sat 0, out_data 0, out_row 0, out_last 0. snap_ready=0 while rst=1 and 1 the cycle after.
- Reset mid-stream discards the remaining rows; there is no partial flush.

## Timing
- Snapshot handshake at edge T → out_valid=1 with row 0 from T+1.
- Throughput is 1 row/cycle with out_ready held high: 16 cycles per tile, zero bubbles between tiles when back-to-back.
- out_valid never drops while STREAM is active and no handshake has occurred.
- out_data, out_row, out_last and out_sat are stable while out_valid && !out_ready.
- snap_valid is ignored when snap_ready=0; acc_array is not sampled then.
- The sat_count update becomes visible the cycle after the row handshake.

## Structure
- Shared package: ACC_W, OUT_W, ROWS, COLS, SHIFT_MAX=23, state encoding, element slice offset (r*COLS*ACC_W + c*ACC_W).
- One sub-module: requant_sat. It is a combinational 24→8 round/shift/saturate for one element and outputs sat_flag. The top instantiates COLS copies on the selected row and feeds a popcount of sat_flags into sat_count.
- Top holds the FSM, the 6144-bit buffer, the row mux, and the counters.

## Test plan
- Ramp: acc(r,c)=r*16+c, shift 0, out_ready=1.
  - → row 0 = 0..15, rows 0–7 exact.
  - → rows 8–15 all 127 with out_sat=1.
  - → out_last only on row 15; sat_count=128 after the tile.
- Rounding at shift 1:
  - acc 5 → 3; acc −5 → −2; acc 0x7FFFFF → 127 (sat).
  - acc −1000 at shift 2 → −128, sat_count += 1.
- Shift clamp: shift=31, acc 0x7FFFFF → 1; acc 0x3FFFFF → 0; acc 0x800000 → −1.
- Backpressure: out_ready=0 for 5 cycles at row 3 → out_valid=1 and out_row=3 with data unchanged for those cycles. Row 4 appears the cycle after out_ready returns.
- Back-to-back: second snapshot presented with snap_valid on the row-15 handshake → accepted that cycle, new row 0 next cycle, 32 rows delivered in 32 cycles.
- Reset at row 9 → next cycle out_valid=0, sat_count=0, state IDLE; snap_ready=1 one cycle after rst deasserts.
